// File: rtl/idec_pipe_if.sv
// Handshake and decoded-field bundle between an instruction source and idec_pipe.
// The master side feeds instructions and consumes fields; the slave side is the decoder.
interface idec_pipe_if #(
    parameter int DATAW  = 32,
    parameter int REGAW  = 4,
    parameter int ALUAW  = 4,
    parameter int FLAGSW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATAW-1:0]  iin;
    logic [FLAGSW-1:0] cpsr_in;
    logic              out_valid;
    logic              out_ready;
    logic [ALUAW-1:0]  alu_out;
    logic [REGAW-1:0]  rn_out;
    logic [REGAW-1:0]  rd_out;
    logic [REGAW-1:0]  rm_out;
    logic [DATAW-1:0]  imm_out;
    logic              imm_en;
    logic              cpsrs_out;
    logic              reg_we;
    logic              mem_we;
    logic              ib;
    logic              bl;
    logic              up_out;
    logic              pre_out;
    logic [DATAW-1:0]  bv;

    modport master (
        output in_valid, iin, cpsr_in, out_ready,
        input  in_ready, out_valid, alu_out, rn_out, rd_out, rm_out, imm_out, imm_en,
               cpsrs_out, reg_we, mem_we, ib, bl, up_out, pre_out, bv
    );

    modport slave (
        input  in_valid, iin, cpsr_in, out_ready,
        output in_ready, out_valid, alu_out, rn_out, rd_out, rm_out, imm_out, imm_en,
               cpsrs_out, reg_we, mem_we, ib, bl, up_out, pre_out, bv
    );
endinterface

// File: rtl/idec_pipe.sv
// Single-stage ARM-style instruction decoder with condition check, valid/ready
// handshake and post-branch squash of a fixed number of accepted instructions.
module idec_pipe #(
    parameter int DATAW       = 32,
    parameter int REGAW       = 4,
    parameter int ALUAW       = 4,
    parameter int FLAGSW      = 4,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    idec_pipe_if.slave  bus
);

    typedef struct packed {
        logic [ALUAW-1:0] alu;
        logic [REGAW-1:0] rn;
        logic [REGAW-1:0] rd;
        logic [REGAW-1:0] rm;
        logic [DATAW-1:0] imm;
        logic             imm_en;
        logic             cpsrs;
        logic             reg_we;
        logic             mem_we;
        logic             ib;
        logic             bl;
        logic             up;
        logic             pre;
        logic [DATAW-1:0] bv;
    } dec_t;

    dec_t       fields_q, fields_d, dec_s;
    logic       out_valid_q, out_valid_d;
    logic [2:0] squash_q, squash_d;
    logic       accept_s, cond_ok_s, drop_s, is_branch_s;
    logic [2*DATAW-1:0] rot_s;

    // Condition code evaluation against flags {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = c && !z;
            4'd9:    r = !c || z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z && (n == v);
            4'd13:   r = z || (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign cond_ok_s    = cond_pass(bus.iin[31:28], bus.cpsr_in[3:0]);
    assign drop_s       = !cond_ok_s || (bus.iin == {DATAW{1'b0}}) || (squash_q != 3'd0);
    assign is_branch_s  = (bus.iin[27:25] == 3'b101);
    // Duplicated word shifted right gives a rotate-right of the 8-bit immediate.
    assign rot_s = {{(DATAW-8){1'b0}}, bus.iin[7:0], {(DATAW-8){1'b0}}, bus.iin[7:0]}
                   >> {bus.iin[11:8], 1'b0};

    // Field decode of the presented word by opcode class; unnamed fields stay 0.
    always_comb begin
        dec_s = '0;
        if (bus.iin[27:26] == 2'b00) begin
            dec_s.alu    = bus.iin[24:21];
            dec_s.rn     = bus.iin[19:16];
            dec_s.rd     = bus.iin[15:12];
            dec_s.cpsrs  = bus.iin[20];
            dec_s.reg_we = 1'b1;
            if (bus.iin[25]) begin
                dec_s.imm_en = 1'b1;
                dec_s.imm    = rot_s[DATAW-1:0];
            end else begin
                dec_s.rm     = bus.iin[3:0];
            end
        end else if (bus.iin[27:26] == 2'b01) begin
            dec_s.rn     = bus.iin[19:16];
            dec_s.rd     = bus.iin[15:12];
            dec_s.reg_we = bus.iin[20];
            dec_s.mem_we = !bus.iin[20];
            dec_s.pre    = bus.iin[24];
            dec_s.up     = bus.iin[23];
            dec_s.alu    = bus.iin[23] ? ALUAW'(4'b0100) : ALUAW'(4'b0010);
            if (bus.iin[25]) begin
                dec_s.rm     = bus.iin[3:0];
            end else begin
                dec_s.imm_en = 1'b1;
                dec_s.imm    = {{(DATAW-12){1'b0}}, bus.iin[11:0]};
            end
        end else if (is_branch_s) begin
            dec_s.ib = 1'b1;
            dec_s.bl = bus.iin[24];
            dec_s.bv = {{(DATAW-26){bus.iin[23]}}, bus.iin[23:0], 2'b00};
        end else begin
            dec_s = '0;
        end
    end

    // Next-state: issue, drop, squash countdown and downstream consumption.
    always_comb begin
        fields_d    = fields_q;
        out_valid_d = out_valid_q;
        squash_d    = squash_q;
        if (accept_s) begin
            if (squash_q != 3'd0) begin
                squash_d = squash_q - 3'd1;
            end else begin
                squash_d = squash_q;
            end
            if (!drop_s) begin
                fields_d    = dec_s;
                out_valid_d = 1'b1;
                if (is_branch_s) begin
                    squash_d = 3'(FLUSH_SLOTS);
                end else begin
                    squash_d = squash_q;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fields_q    <= '0;
            out_valid_q <= 1'b0;
            squash_q    <= 3'd0;
        end else begin
            fields_q    <= fields_d;
            out_valid_q <= out_valid_d;
            squash_q    <= squash_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = fields_q.alu;
    assign bus.rn_out    = fields_q.rn;
    assign bus.rd_out    = fields_q.rd;
    assign bus.rm_out    = fields_q.rm;
    assign bus.imm_out   = fields_q.imm;
    assign bus.imm_en    = fields_q.imm_en;
    assign bus.cpsrs_out = fields_q.cpsrs;
    assign bus.reg_we    = fields_q.reg_we;
    assign bus.mem_we    = fields_q.mem_we;
    assign bus.ib        = fields_q.ib;
    assign bus.bl        = fields_q.bl;
    assign bus.up_out    = fields_q.up;
    assign bus.pre_out   = fields_q.pre;
    assign bus.bv        = fields_q.bv;

endmodule

// File: tb/tb_idec_pipe.sv
// Directed bench for idec_pipe: hand-computed expectations checked one step at a time.
module tb_idec_pipe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    idec_pipe_if #(.DATAW(32), .REGAW(4), .ALUAW(4), .FLAGSW(4)) bus_if ();

    idec_pipe #(.DATAW(32), .REGAW(4), .ALUAW(4), .FLAGSW(4), .FLUSH_SLOTS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [3:0] f, input logic rdy);
        bus_if.in_valid  = v;
        bus_if.iin       = w;
        bus_if.cpsr_in   = f;
        bus_if.out_ready = rdy;
    endtask

    localparam logic [31:0] ADD1 = 32'hE0810002;  // ADD r0,r1,r2
    localparam logic [31:0] ADD3 = 32'hE0843005;  // ADD r3,r4,r5
    localparam logic [31:0] MOVI = 32'hE3A004FF;  // MOV r0,#0xFF ror 8
    localparam logic [31:0] BLM2 = 32'hEBFFFFFE;  // BL -8
    localparam logic [31:0] LDR  = 32'hE5912004;  // LDR r2,[r1,#4]
    localparam logic [31:0] STR  = 32'hE5012004;  // STR r2,[r1,#-4]

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        step();
        step();
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        chk("rst_alu", {28'd0, bus_if.alu_out}, 32'd0);
        chk("rst_bv", bus_if.bv, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, bus_if.in_ready}, 32'd1);

        // Data processing, register operand
        drive(1'b1, ADD1, 4'h0, 1'b1);
        step();
        chk("add_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("add_alu", {28'd0, bus_if.alu_out}, 32'd4);
        chk("add_rn", {28'd0, bus_if.rn_out}, 32'd1);
        chk("add_rd", {28'd0, bus_if.rd_out}, 32'd0);
        chk("add_rm", {28'd0, bus_if.rm_out}, 32'd2);
        chk("add_imm_en", {31'd0, bus_if.imm_en}, 32'd0);
        chk("add_reg_we", {31'd0, bus_if.reg_we}, 32'd1);
        chk("add_mem_we", {31'd0, bus_if.mem_we}, 32'd0);

        // Data processing, rotated immediate
        drive(1'b1, MOVI, 4'h0, 1'b1);
        step();
        chk("mov_imm_en", {31'd0, bus_if.imm_en}, 32'd1);
        chk("mov_imm", bus_if.imm_out, 32'hFF000000);
        chk("mov_alu", {28'd0, bus_if.alu_out}, 32'd13);
        chk("mov_rm_zero", {28'd0, bus_if.rm_out}, 32'd0);

        // Branch with link, then two squashed ADDs and a third that issues
        drive(1'b1, BLM2, 4'h0, 1'b1);
        step();
        chk("bl_ib", {31'd0, bus_if.ib}, 32'd1);
        chk("bl_bl", {31'd0, bus_if.bl}, 32'd1);
        chk("bl_bv", bus_if.bv, 32'hFFFFFFF8);
        chk("bl_reg_we", {31'd0, bus_if.reg_we}, 32'd0);
        drive(1'b1, ADD1, 4'h0, 1'b1);
        step();
        chk("sq1_valid", {31'd0, bus_if.out_valid}, 32'd0);
        step();
        chk("sq2_valid", {31'd0, bus_if.out_valid}, 32'd0);
        drive(1'b1, ADD3, 4'h0, 1'b1);
        step();
        chk("post_sq_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("post_sq_rd", {28'd0, bus_if.rd_out}, 32'd3);
        chk("post_sq_rn", {28'd0, bus_if.rn_out}, 32'd4);
        chk("post_sq_rm", {28'd0, bus_if.rm_out}, 32'd5);
        chk("post_sq_ib", {31'd0, bus_if.ib}, 32'd0);

        // Load and store
        drive(1'b1, LDR, 4'h0, 1'b1);
        step();
        chk("ldr_alu", {28'd0, bus_if.alu_out}, 32'd4);
        chk("ldr_we", {30'd0, bus_if.reg_we, bus_if.mem_we}, 32'd2);
        chk("ldr_imm", bus_if.imm_out, 32'h4);
        chk("ldr_pre_up", {30'd0, bus_if.pre_out, bus_if.up_out}, 32'd3);
        drive(1'b1, STR, 4'h0, 1'b1);
        step();
        chk("str_alu", {28'd0, bus_if.alu_out}, 32'd2);
        chk("str_we", {30'd0, bus_if.reg_we, bus_if.mem_we}, 32'd1);
        chk("str_up", {31'd0, bus_if.up_out}, 32'd0);

        // Unknown class issues as a no-op; condition 1111 and zero word drop
        drive(1'b1, 32'hE8000000, 4'h0, 1'b1);
        step();
        chk("nop_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("nop_reg_we", {31'd0, bus_if.reg_we}, 32'd0);
        chk("nop_imm", bus_if.imm_out, 32'd0);
        drive(1'b1, 32'hF0810002, 4'h0, 1'b1);
        step();
        chk("nv_drop", {31'd0, bus_if.out_valid}, 32'd0);
        drive(1'b1, 32'h0, 4'h0, 1'b1);
        step();
        chk("zero_drop", {31'd0, bus_if.out_valid}, 32'd0);

        // BNE with Z=1 drops without arming squash; BEQ issues
        drive(1'b1, 32'h1A000000, 4'h4, 1'b1);
        step();
        chk("bne_drop", {31'd0, bus_if.out_valid}, 32'd0);
        drive(1'b1, ADD1, 4'h4, 1'b1);
        step();
        chk("bne_no_squash", {31'd0, bus_if.out_valid}, 32'd1);
        drive(1'b1, 32'h0A000000, 4'h4, 1'b1);
        step();
        chk("beq_ib", {31'd0, bus_if.ib}, 32'd1);
        chk("beq_bl", {31'd0, bus_if.bl}, 32'd0);
        chk("beq_bv", bus_if.bv, 32'd0);

        // One squashed ADD leaves one slot; reset clears it
        drive(1'b1, ADD1, 4'h0, 1'b1);
        step();
        chk("sq_before_rst", {31'd0, bus_if.out_valid}, 32'd0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, ADD3, 4'h0, 1'b1);
        step();
        chk("after_rst_issue", {31'd0, bus_if.out_valid}, 32'd1);
        chk("after_rst_rd", {28'd0, bus_if.rd_out}, 32'd3);

        // Back-pressure: ADD1 issues then holds for 3 cycles while MOV waits
        drive(1'b1, ADD1, 4'h0, 1'b1);
        step();
        drive(1'b1, MOVI, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
            step();
            chk("stall_valid", {31'd0, bus_if.out_valid}, 32'd1);
            chk("stall_rm", {28'd0, bus_if.rm_out}, 32'd2);
            chk("stall_imm_en", {31'd0, bus_if.imm_en}, 32'd0);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        step();
        chk("release_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("release_imm", bus_if.imm_out, 32'hFF000000);
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        step();
        chk("drain_valid", {31'd0, bus_if.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/idec_pipe.md
IDEC_PIPE -- requirements
Module: idec_pipe

Interface
REQ-001 Parameter DATAW, default 32, instruction, branch-value and immediate width.
REQ-002 Parameter REGAW, default 4, register address width.
REQ-003 Parameter ALUAW, default 4, ALU opcode width.
REQ-004 Parameter FLAGSW, default 4, CPSR flag width; bit order {N,Z,C,V} in bits [3:0].
REQ-005 Parameter FLUSH_SLOTS, default 2, range 0..7, number of accepted instructions squashed after an issued branch.
REQ-006 clk  in  1  rising-edge clock; single clock domain.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 in_valid  in  1  upstream instruction valid.
REQ-009 in_ready  out  1  block accepts an instruction this cycle.
REQ-010 iin  in  DATAW  instruction word.
REQ-011 cpsr_in  in  FLAGSW  current flags, sampled with iin.
REQ-012 out_valid  out  1  decoded fields valid.
REQ-013 out_ready  in  1  downstream consumes fields.
REQ-014 alu_out  out  ALUAW; rn_out, rd_out, rm_out  out  REGAW each; operand fields.
REQ-015 imm_out  out  DATAW  decoded immediate operand; imm_en  out  1  selects imm_out over rm_out.
REQ-016 cpsrs_out, reg_we, mem_we, ib, bl, up_out, pre_out  out  1 each  control flags.
REQ-017 bv  out  DATAW  branch byte offset.

Function
REQ-018 in_ready SHALL equal rst_n && (!out_valid || out_ready); an instruction is accepted when in_valid && in_ready.
REQ-019 All outputs except in_ready SHALL be registered; they SHALL hold while out_valid && !out_ready.
REQ-020 Condition check on iin[31:28] vs cpsr_in SHALL implement EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; code 1111 SHALL fail.
REQ-021 An accepted instruction SHALL be dropped (out_valid 0 next cycle unless otherwise loaded, no field update) if: condition fails, iin == 0, or squash_cnt != 0.
REQ-022 Dropped instructions while squash_cnt != 0 SHALL decrement squash_cnt by 1; condition-failed or zero words outside squash SHALL not affect squash_cnt.
REQ-023 A non-dropped accepted instruction SHALL set out_valid 1 on the next edge with the decoded fields; latency exactly 1 cycle.
REQ-024 If out_valid && out_ready and no new issue, out_valid SHALL clear on the next edge.
REQ-025 iin[27:26]==00 (data processing): alu_out=iin[24:21], rn_out=iin[19:16], rd_out=iin[15:12], cpsrs_out=iin[20], reg_we=1, mem_we=0.
REQ-026 Data processing with iin[25]=1: imm_en=1, imm_out = zero-extended iin[7:0] rotated right by 2*iin[11:8] within 32 bits; iin[25]=0: imm_en=0, rm_out=iin[3:0].
REQ-027 iin[27:26]==01 (load/store): rn_out, rd_out as REQ-025; reg_we=iin[20]; mem_we=~iin[20]; cpsrs_out=0; pre_out=iin[24]; up_out=iin[23]; alu_out = 0100 if iin[23]=1 else 0010; iin[25]=0: imm_en=1, imm_out=zero-extended iin[11:0]; iin[25]=1: imm_en=0, rm_out=iin[3:0].
REQ-028 iin[27:25]==101 (branch): ib=1, bl=iin[24], bv=sign-extend(iin[23:0])<<2; reg_we, mem_we, cpsrs_out=0; squash_cnt SHALL load FLUSH_SLOTS on the issue edge.
REQ-029 Any other opcode class SHALL issue as a no-op: out_valid=1, all enables 0, fields 0.
REQ-030 Fields not named for a class SHALL be 0.
REQ-031 A branch arriving while squash_cnt != 0 SHALL be squashed and SHALL not reload squash_cnt.
REQ-032 Stall does not decrement squash_cnt; only accepted instructions count.

Reset
REQ-033 On rising clk with rst_n=0: out_valid=0, squash_cnt=0, all registered outputs 0; in_ready=0 while rst_n=0.
REQ-034 Reset asserted mid-stall or mid-squash SHALL discard the held output and the remaining squash count.

Verification
REQ-035 Reset, then iin=0xE0810002 (ADD r0,r1,r2, AL), out_ready=1 -> next cycle out_valid=1, alu_out=0100, rn=1, rd=0, rm=2, imm_en=0, reg_we=1.
REQ-036 iin=0xE3A004FF (MOV r0,#0xFF ror 8) -> imm_en=1, imm_out=0xFF000000.
REQ-037 iin=0xEBFFFFFE then three ADDs back-to-back, FLUSH_SLOTS=2 -> ib=1, bl=1, bv=0xFFFFFFF8; first two ADDs dropped, third issues.
REQ-038 cpsr_in=0100 (Z=1), iin=0x1A000000 (BNE) -> dropped, squash_cnt stays 0; iin=0x0A000000 (BEQ) -> ib=1.
REQ-039 Issue ADD with out_ready=0 for 3 cycles -> in_ready=0, fields stable, out_valid=1; out_ready=1 -> consumed, next instruction accepted same cycle.
REQ-040 rst_n=0 during squash window (squash_cnt=1) -> after release, next ADD issues normally.
